// File: rtl/ps_lane_scheduler.sv
// Round-robin byte-slot scheduler: after a fixed run of idle sync slots it grants one
// of four requesters per SLOT_LEN-cycle slot and holds the granted byte for the serializer.
module ps_lane_scheduler #(
    parameter int          SLOT_LEN   = 8,
    parameter int          SYNC_SLOTS = 4,
    parameter logic [7:0]  IDLE_CHAR  = 8'hBC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  en_mask,
    output logic [3:0]  req_ready,
    output logic [7:0]  data_in_8b,
    output logic        valid,
    output logic [1:0]  grant_id,
    output logic        slot_strobe,
    output logic [15:0] byte_count
);

    localparam int SLOT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int SYNC_W = $clog2(SYNC_SLOTS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_SLOTS - 1);

    typedef enum logic {
        ST_SYNC,
        ST_ARB
    } state_t;

    state_t             state_reg, state_next;
    logic [SLOT_W-1:0]  slot_cnt_reg;
    logic [SYNC_W-1:0]  sync_cnt_reg, sync_cnt_next;
    logic [1:0]         ptr_reg, ptr_next;
    logic [7:0]         data_reg, data_next;
    logic               valid_reg, valid_next;
    logic [1:0]         gid_reg, gid_next;
    logic [15:0]        count_reg, count_next;

    logic               strobe_int;
    logic [3:0]         eligible;
    logic [1:0]         cand_idx [4];
    logic [3:0]         cand_hit;
    logic [7:0]         lane_byte [4];
    logic [1:0]         winner;
    logic               any_hit;

    assign strobe_int  = (slot_cnt_reg == SLOT_LAST);
    assign slot_strobe = strobe_int & ~reset;
    assign eligible    = req_valid & en_mask;

    // Candidate k is the requester k places above the round-robin pointer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign cand_idx[gi]  = ptr_reg + 2'(gi);
            assign cand_hit[gi]  = eligible[cand_idx[gi]];
            assign lane_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Walk from the farthest candidate down so the nearest hit wins.
    always_comb begin
        winner  = cand_idx[0];
        any_hit = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner  = cand_idx[k];
                any_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        sync_cnt_next = sync_cnt_reg;
        ptr_next      = ptr_reg;
        data_next     = data_reg;
        valid_next    = valid_reg;
        gid_next      = gid_reg;
        count_next    = count_reg;
        req_ready     = 4'b0000;
        case (state_reg)
            ST_SYNC: begin
                if (strobe_int) begin
                    if (sync_cnt_reg == SYNC_LAST) begin
                        state_next    = ST_ARB;
                        sync_cnt_next = '0;
                    end else begin
                        sync_cnt_next = sync_cnt_reg + 1'b1;
                    end
                end
            end
            ST_ARB: begin
                if (strobe_int) begin
                    if (any_hit) begin
                        req_ready  = 4'b0001 << winner;
                        data_next  = lane_byte[winner];
                        valid_next = 1'b1;
                        gid_next   = winner;
                        ptr_next   = winner + 2'd1;
                        count_next = count_reg + 16'd1;
                    end else begin
                        data_next  = IDLE_CHAR;
                        valid_next = 1'b0;
                    end
                end
            end
            default: state_next = ST_SYNC;
        endcase
        // A grant offered while reset is high would be discarded, so never offer it.
        if (reset) begin
            req_ready = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_SYNC;
            slot_cnt_reg <= '0;
            sync_cnt_reg <= '0;
            ptr_reg      <= 2'd0;
            data_reg     <= IDLE_CHAR;
            valid_reg    <= 1'b0;
            gid_reg      <= 2'd0;
            count_reg    <= 16'd0;
        end else begin
            state_reg    <= state_next;
            slot_cnt_reg <= strobe_int ? '0 : slot_cnt_reg + 1'b1;
            sync_cnt_reg <= sync_cnt_next;
            ptr_reg      <= ptr_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            gid_reg      <= gid_next;
            count_reg    <= count_next;
        end
    end

    assign data_in_8b = data_reg;
    assign valid      = valid_reg;
    assign grant_id   = gid_reg;
    assign byte_count = count_reg;

endmodule

// File: tb/tb_ps_lane_scheduler.sv
// Bench for ps_lane_scheduler: slot-level vector table, reset corner sequences and
// randomized traffic checked every cycle against a slot-arithmetic reference model.
module tb_ps_lane_scheduler;

    localparam int SLOT = 8;
    localparam int SYNC = 4;
    localparam logic [7:0] IDLE = 8'hBC;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  en_mask;
    logic [3:0]  req_ready;
    logic [7:0]  data_in_8b;
    logic        valid;
    logic [1:0]  grant_id;
    logic        slot_strobe;
    logic [15:0] byte_count;

    ps_lane_scheduler #(.SLOT_LEN(SLOT), .SYNC_SLOTS(SYNC), .IDLE_CHAR(IDLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .en_mask    (en_mask),
        .req_ready  (req_ready),
        .data_in_8b (data_in_8b),
        .valid      (valid),
        .grant_id   (grant_id),
        .slot_strobe(slot_strobe),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: position in the slot grid since release plus grant history.
    int          n;
    int          m_ptr;
    logic [7:0]  m_data;
    logic        m_valid;
    int          m_gid;
    logic [15:0] m_cnt;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  en;
        logic [31:0] d;
        logic [3:0]  rdy;
        logic [1:0]  gid;
        logic [7:0]  dat;
        logic        vld;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        n       = 0;
        m_ptr   = 0;
        m_data  = IDLE;
        m_valid = 1'b0;
        m_gid   = 0;
        m_cnt   = 16'd0;
    endtask

    // One clock: compare at negedge, then advance the model across the rising edge.
    task automatic step(output logic [3:0] rdy_seen);
        logic [3:0] elig;
        logic [3:0] exp_ready;
        int         w;
        bit         strobe;
        bit         arb;
        @(negedge clk);
        strobe    = !reset && (n % SLOT == SLOT - 1);
        arb       = (n / SLOT) >= SYNC;
        exp_ready = 4'b0000;
        w         = -1;
        if (strobe && arb) begin
            elig = req_valid & en_mask;
            for (int k = 0; k < 4; k++)
                if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        rdy_seen = req_ready;
        check("req_ready",   32'(req_ready),   32'(exp_ready));
        check("slot_strobe", 32'(slot_strobe), 32'(strobe));
        check("data_in_8b",  32'(data_in_8b),  32'(m_data));
        check("valid",       32'(valid),       32'(m_valid));
        check("grant_id",    32'(grant_id),    32'(m_gid));
        check("byte_count",  32'(byte_count),  32'(m_cnt));
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (strobe && arb) begin
                if (w >= 0) begin
                    m_data  = req_data[8*w +: 8];
                    m_valid = 1'b1;
                    m_gid   = w;
                    m_ptr   = (w + 1) % 4;
                    m_cnt   = m_cnt + 16'd1;
                end else begin
                    m_data  = IDLE;
                    m_valid = 1'b0;
                end
            end
            n++;
        end
        #1;
    endtask

    // Spend one cycle with reset held, checking the fixed reset-state values.
    task automatic check_reset(input string tag);
        @(negedge clk);
        check({tag, "_data"},   32'(data_in_8b),  32'(8'hBC));
        check({tag, "_valid"},  32'(valid),       32'd0);
        check({tag, "_gid"},    32'(grant_id),    32'd0);
        check({tag, "_count"},  32'(byte_count),  32'd0);
        check({tag, "_ready"},  32'(req_ready),   32'd0);
        check({tag, "_strobe"}, 32'(slot_strobe), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rdy;

        // ptr carries across entries: see grant order 0,1,2,3,0 then 2s, then 3,1,3,1, idle, 2.
        tbl[0]  = '{4'hF, 4'hF, 32'h43322110, 4'b0001, 2'd0, 8'h10, 1'b1, 16'd1};
        tbl[1]  = '{4'hF, 4'hF, 32'h43322110, 4'b0010, 2'd1, 8'h21, 1'b1, 16'd2};
        tbl[2]  = '{4'hF, 4'hF, 32'h43322110, 4'b0100, 2'd2, 8'h32, 1'b1, 16'd3};
        tbl[3]  = '{4'hF, 4'hF, 32'h43322110, 4'b1000, 2'd3, 8'h43, 1'b1, 16'd4};
        tbl[4]  = '{4'hF, 4'hF, 32'h43322110, 4'b0001, 2'd0, 8'h10, 1'b1, 16'd5};
        tbl[5]  = '{4'h4, 4'hF, 32'h43A52110, 4'b0100, 2'd2, 8'hA5, 1'b1, 16'd6};
        tbl[6]  = '{4'h4, 4'hF, 32'h43A52110, 4'b0100, 2'd2, 8'hA5, 1'b1, 16'd7};
        tbl[7]  = '{4'h4, 4'hF, 32'h43A52110, 4'b0100, 2'd2, 8'hA5, 1'b1, 16'd8};
        tbl[8]  = '{4'hF, 4'hA, 32'h43322110, 4'b1000, 2'd3, 8'h43, 1'b1, 16'd9};
        tbl[9]  = '{4'hF, 4'hA, 32'h43322110, 4'b0010, 2'd1, 8'h21, 1'b1, 16'd10};
        tbl[10] = '{4'hF, 4'hA, 32'h43322110, 4'b1000, 2'd3, 8'h43, 1'b1, 16'd11};
        tbl[11] = '{4'hF, 4'hA, 32'h43322110, 4'b0010, 2'd1, 8'h21, 1'b1, 16'd12};
        tbl[12] = '{4'h0, 4'hF, 32'h43322110, 4'b0000, 2'd1, 8'hBC, 1'b0, 16'd12};
        tbl[13] = '{4'h0, 4'hF, 32'h43322110, 4'b0000, 2'd1, 8'hBC, 1'b0, 16'd12};
        tbl[14] = '{4'hF, 4'hF, 32'h43322110, 4'b0100, 2'd2, 8'h32, 1'b1, 16'd13};

        reset     = 1'b1;
        req_valid = 4'hF;
        en_mask   = 4'hF;
        req_data  = 32'h43322110;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        reset = 1'b0;
        model_reset();

        // Sync phase: 32 idle cycles, then one slot until the first grant at cycle 39.
        repeat (SYNC * SLOT) step(rdy);

        foreach (tbl[i]) begin
            req_valid = tbl[i].v;
            en_mask   = tbl[i].en;
            req_data  = tbl[i].d;
            for (int j = 0; j < SLOT; j++) begin
                step(rdy);
                if (j == SLOT - 1) check($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
            end
            check($sformatf("tbl%0d_gid", i),   32'(grant_id),   32'(tbl[i].gid));
            check($sformatf("tbl%0d_data", i),  32'(data_in_8b), 32'(tbl[i].dat));
            check($sformatf("tbl%0d_valid", i), 32'(valid),      32'(tbl[i].vld));
            check($sformatf("tbl%0d_count", i), 32'(byte_count), 32'(tbl[i].cnt));
        end

        // Reset three cycles into a slot.
        req_valid = 4'hF;
        en_mask   = 4'hF;
        repeat (3) step(rdy);
        reset = 1'b1;
        step(rdy);
        check_reset("midslot");
        reset = 1'b0;

        // Reset landing on the first ARB strobe discards the pending grant.
        repeat (SYNC * SLOT + SLOT - 1) step(rdy);
        reset = 1'b1;
        step(rdy);
        check_reset("midgrant");
        reset = 1'b0;

        // Randomized traffic with inputs changing mid-slot and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) req_valid = 4'($urandom);
            if ($urandom_range(0, 5) == 0) en_mask   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            req_data = $urandom;
            reset    = ($urandom_range(0, 499) == 0);
            step(rdy);
        end
        reset = 1'b0;
        step(rdy);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
